// File: rtl/led_pkg.sv
// Shared definitions for the scrolling 7-segment driver.
// Contents: character codes, active-low segment constants and the FSM state encoding.
package led_pkg;

    localparam logic [5:0] CH_0 = 6'd0;
    localparam logic [5:0] CH_1 = 6'd1;
    localparam logic [5:0] CH_2 = 6'd2;
    localparam logic [5:0] CH_3 = 6'd3;
    localparam logic [5:0] CH_4 = 6'd4;
    localparam logic [5:0] CH_5 = 6'd5;
    localparam logic [5:0] CH_6 = 6'd6;
    localparam logic [5:0] CH_7 = 6'd7;
    localparam logic [5:0] CH_8 = 6'd8;
    localparam logic [5:0] CH_9 = 6'd9;
    localparam logic [5:0] CH_A = 6'd10;
    localparam logic [5:0] CH_B = 6'd11;
    localparam logic [5:0] CH_C = 6'd12;
    localparam logic [5:0] CH_D = 6'd13;
    localparam logic [5:0] CH_E = 6'd14;
    localparam logic [5:0] CH_F = 6'd15;
    localparam logic [5:0] CH_G = 6'd16;
    localparam logic [5:0] CH_H = 6'd17;
    localparam logic [5:0] CH_I = 6'd18;
    localparam logic [5:0] CH_J = 6'd19;
    localparam logic [5:0] CH_K = 6'd20;
    localparam logic [5:0] CH_L = 6'd21;
    localparam logic [5:0] CH_M = 6'd22;
    localparam logic [5:0] CH_N = 6'd23;
    localparam logic [5:0] CH_O = 6'd24;
    localparam logic [5:0] CH_P = 6'd25;
    localparam logic [5:0] CH_Q = 6'd26;
    localparam logic [5:0] CH_R = 6'd27;
    localparam logic [5:0] CH_S = 6'd28;
    localparam logic [5:0] CH_T = 6'd29;
    localparam logic [5:0] CH_U = 6'd30;
    localparam logic [5:0] CH_V = 6'd31;
    localparam logic [5:0] CH_W = 6'd32;
    localparam logic [5:0] CH_X = 6'd33;
    localparam logic [5:0] CH_Y = 6'd34;
    localparam logic [5:0] CH_Z = 6'd35;
    localparam logic [5:0] CH_SPACE = 6'd36;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/char_seg_decoder.sv
// Combinational char code -> active-low a..g pattern (bit6 = a).
// Codes above CH_SPACE show a dash.
module char_seg_decoder
    import led_pkg::*;
(
    input  logic [5:0] code_i,
    output logic [6:0] seg_o
);

    logic [6:0] lit;  // active-high abcdefg, inverted on the way out

    always_comb begin
        lit = ~SEG_DASH;
        case (code_i)
            CH_0:     lit = 7'b1111110;
            CH_1:     lit = 7'b0110000;
            CH_2:     lit = 7'b1101101;
            CH_3:     lit = 7'b1111001;
            CH_4:     lit = 7'b0110011;
            CH_5:     lit = 7'b1011011;
            CH_6:     lit = 7'b1011111;
            CH_7:     lit = 7'b1110000;
            CH_8:     lit = 7'b1111111;
            CH_9:     lit = 7'b1111011;
            CH_A:     lit = 7'b1110111;
            CH_B:     lit = 7'b0011111;
            CH_C:     lit = 7'b1001110;
            CH_D:     lit = 7'b0111101;
            CH_E:     lit = 7'b1001111;
            CH_F:     lit = 7'b1000111;
            CH_G:     lit = 7'b1011110;
            CH_H:     lit = 7'b0110111;
            CH_I:     lit = 7'b0110000;
            CH_J:     lit = 7'b0111000;
            CH_K:     lit = 7'b1010111;
            CH_L:     lit = 7'b0001110;
            CH_M:     lit = 7'b1010100;
            CH_N:     lit = 7'b0010101;
            CH_O:     lit = 7'b0011101;
            CH_P:     lit = 7'b1100111;
            CH_Q:     lit = 7'b1110011;
            CH_R:     lit = 7'b0000101;
            CH_S:     lit = 7'b1011011;
            CH_T:     lit = 7'b0001111;
            CH_U:     lit = 7'b0111110;
            CH_V:     lit = 7'b0011100;
            CH_W:     lit = 7'b0101010;
            CH_X:     lit = 7'b0110110;
            CH_Y:     lit = 7'b0111011;
            CH_Z:     lit = 7'b1101101;
            CH_SPACE: lit = 7'b0000000;
            default:  lit = ~SEG_DASH;
        endcase
        seg_o = ~lit;
    end

endmodule

// File: rtl/led_scroll_driver.sv
// Multiplexed N-digit common-anode 7-segment driver scrolling a stored message.
// Optional feature macro LED_BLINK_EN adds a blink input that blanks the second half of each scroll period in RUN.
module led_scroll_driver
    import led_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int MSG_DEPTH   = 16,
    parameter int REFRESH_DIV = 50000,
    parameter int SCROLL_DIV  = 25_000_000,
    localparam int ADDR_W = $clog2(MSG_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [5:0]            wr_data,
    input  logic [ADDR_W:0]       msg_len,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  stop,
`ifdef LED_BLINK_EN
    input  logic                  blink,
`endif
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            LED,
    output logic                  busy,
    output logic                  wrap
);

    localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SC_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int DG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [RC_W-1:0]   REF_LAST = RC_W'(REFRESH_DIV - 1);
    localparam logic [SC_W-1:0]   SCR_LAST = SC_W'(SCROLL_DIV - 1);
    localparam logic [DG_W-1:0]   DIG_LAST = DG_W'(NUM_DIGITS - 1);
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(MSG_DEPTH);

    logic [5:0]            mem_q [MSG_DEPTH];
    state_e                state_q, state_d;
    logic [RC_W-1:0]       ref_cnt_q, ref_cnt_d;
    logic [SC_W-1:0]       scr_cnt_q, scr_cnt_d;
    logic [DG_W-1:0]       digit_q, digit_d;
    logic [ADDR_W-1:0]     ptr_q, ptr_d, base_q, base_d;
    logic [ADDR_W:0]       len_q, len_d;
    logic                  wrap_q, wrap_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            led_q, led_d, seg_code;
    logic                  restart, blank_d;

    // NOTE: the buffer has no reset so it maps onto plain RAM; its contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    char_seg_decoder u_dec (
        .code_i (mem_q[ptr_q]),
        .seg_o  (seg_code)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start && msg_len != '0) begin
            state_d = ST_RUN;
            restart = 1'b1;
        end else if (pause) begin
            if (state_q == ST_RUN)       state_d = ST_HOLD;
            else if (state_q == ST_HOLD) state_d = ST_RUN;
        end
    end

    always_comb begin
        ref_cnt_d = ref_cnt_q;
        scr_cnt_d = scr_cnt_q;
        digit_d   = digit_q;
        ptr_d     = ptr_q;
        base_d    = base_q;
        len_d     = len_q;
        wrap_d    = 1'b0;
        if (restart) begin
            len_d     = (msg_len > DEPTH_V) ? DEPTH_V : msg_len;
            ref_cnt_d = '0;
            scr_cnt_d = '0;
            digit_d   = '0;
            ptr_d     = '0;
            base_d    = '0;
        end else if (state_q != ST_IDLE) begin
            if (state_q == ST_RUN) begin
                if (scr_cnt_q == SCR_LAST) begin
                    scr_cnt_d = '0;
                    base_d = (({1'b0, base_q} + (ADDR_W + 1)'(1)) == len_q) ? '0 : base_q + ADDR_W'(1);
                    wrap_d = (base_d == '0);
                end else begin
                    scr_cnt_d = scr_cnt_q + SC_W'(1);
                end
            end
            if (ref_cnt_q == REF_LAST) begin
                ref_cnt_d = '0;
                // A new frame picks up the base as it stands after this edge's scroll step.
                if (digit_q == DIG_LAST) begin
                    digit_d = '0;
                    ptr_d   = base_d;
                end else begin
                    digit_d = digit_q + DG_W'(1);
                    ptr_d = (({1'b0, ptr_q} + (ADDR_W + 1)'(1)) == len_q) ? '0 : ptr_q + ADDR_W'(1);
                end
            end else begin
                ref_cnt_d = ref_cnt_q + RC_W'(1);
            end
        end
    end

    // First cycle of each slot stays dark while the next char is fetched and decoded.
    always_comb begin
        blank_d = (state_d == ST_IDLE) || (ref_cnt_d == '0);
`ifdef LED_BLINK_EN
        if (blink && state_d == ST_RUN && scr_cnt_d >= SC_W'(SCROLL_DIV / 2)) blank_d = 1'b1;
`endif
        an_d  = blank_d ? '1 : ~(NUM_DIGITS'(1) << (DIG_LAST - digit_d));
        led_d = led_q;
        if (state_d == ST_IDLE)                            led_d = SEG_BLANK;
        else if (state_q != ST_IDLE && ref_cnt_q == '0)    led_d = seg_code;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ref_cnt_q <= '0;
            scr_cnt_q <= '0;
            digit_q   <= '0;
            ptr_q     <= '0;
            base_q    <= '0;
            len_q     <= '0;
            wrap_q    <= 1'b0;
            an_q      <= '1;
            led_q     <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            ref_cnt_q <= ref_cnt_d;
            scr_cnt_q <= scr_cnt_d;
            digit_q   <= digit_d;
            ptr_q     <= ptr_d;
            base_q    <= base_d;
            len_q     <= len_d;
            wrap_q    <= wrap_d;
            an_q      <= an_d;
            led_q     <= led_d;
        end
    end

    assign an   = an_q;
    assign LED  = led_q;
    assign busy = (state_q != ST_IDLE);
    assign wrap = wrap_q;

endmodule

// File: tb/tb_led_scroll_driver.sv
// Self-checking bench for led_scroll_driver: directed scenarios plus randomized
// traffic against a time-based reference model of the scrolling display.
module tb_led_scroll_driver;

    localparam int ND = 4;
    localparam int DEPTH = 8;
    localparam int RD = 4;
    localparam int SD = 64;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [5:0] wr_data = '0;
    logic [3:0] msg_len = '0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] an;
    logic [6:0] LED;
    logic       busy;
    logic       wrap;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: t = cycles since last start, run = cycles spent in RUN since start.
    logic [5:0] msg [DEPTH];
    int m_mode = M_IDLE;
    int m_len = 0;
    int m_t = 0;
    int m_run = 0;
    int m_fbase = 0;
    bit m_wrap = 1'b0;

    always #5 clk = ~clk;

    led_scroll_driver #(
        .NUM_DIGITS  (ND),
        .MSG_DEPTH   (DEPTH),
        .REFRESH_DIV (RD),
        .SCROLL_DIV  (SD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .msg_len (msg_len),
        .start   (start),
        .pause   (pause),
        .stop    (stop),
`ifdef LED_BLINK_EN
        .blink   (1'b0),
`endif
        .an      (an),
        .LED     (LED),
        .busy    (busy),
        .wrap    (wrap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at time %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int code);
        logic [6:0] lit;
        case (code)
            0:  lit = 7'b1111110;  1:  lit = 7'b0110000;  2:  lit = 7'b1101101;
            3:  lit = 7'b1111001;  4:  lit = 7'b0110011;  5:  lit = 7'b1011011;
            6:  lit = 7'b1011111;  7:  lit = 7'b1110000;  8:  lit = 7'b1111111;
            9:  lit = 7'b1111011;  10: lit = 7'b1110111;  11: lit = 7'b0011111;
            12: lit = 7'b1001110;  13: lit = 7'b0111101;  14: lit = 7'b1001111;
            15: lit = 7'b1000111;  16: lit = 7'b1011110;  17: lit = 7'b0110111;
            18: lit = 7'b0110000;  19: lit = 7'b0111000;  20: lit = 7'b1010111;
            21: lit = 7'b0001110;  22: lit = 7'b1010100;  23: lit = 7'b0010101;
            24: lit = 7'b0011101;  25: lit = 7'b1100111;  26: lit = 7'b1110011;
            27: lit = 7'b0000101;  28: lit = 7'b1011011;  29: lit = 7'b0001111;
            30: lit = 7'b0111110;  31: lit = 7'b0011100;  32: lit = 7'b0101010;
            33: lit = 7'b0110110;  34: lit = 7'b0111011;  35: lit = 7'b1101101;
            36: lit = 7'b0000000;
            default: lit = 7'b0000001;
        endcase
        return ~lit;
    endfunction

    function automatic int m_base();
        return (m_run / SD) % m_len;
    endfunction

    // Advance the model across one clock edge using the inputs currently applied.
    task automatic model_edge();
        m_wrap = 1'b0;
        if (reset) begin
            m_mode = M_IDLE; m_len = 0; m_t = 0; m_run = 0; m_fbase = 0;
        end else begin
            if (m_mode != M_IDLE) begin
                if (m_mode == M_RUN) begin
                    m_run++;
                    if (m_run % SD == 0 && m_base() == 0) m_wrap = 1'b1;
                end
                m_t++;
                if (m_t % (RD * ND) == 0) m_fbase = m_base();
            end
            if (stop) begin
                m_mode = M_IDLE;
            end else if (start && msg_len != 0) begin
                m_mode = M_RUN;
                m_len = (int'(msg_len) > DEPTH) ? DEPTH : int'(msg_len);
                m_t = 0; m_run = 0; m_fbase = 0; m_wrap = 1'b0;
            end else if (pause && m_mode != M_IDLE) begin
                m_mode = (m_mode == M_RUN) ? M_HOLD : M_RUN;
            end
        end
        if (wr_en) msg[wr_addr] = wr_data;
    endtask

    task automatic compare();
        int d;
        check("busy", busy, 32'(m_mode != M_IDLE));
        check("wrap", wrap, 32'(m_wrap));
        if (m_mode == M_IDLE) begin
            check("idle_an", an, 32'h0F);
            check("idle_led", LED, 32'h7F);
        end else if (m_t % RD == 0) begin
            check("ghost_an", an, 32'h0F);
        end else begin
            d = (m_t / RD) % ND;
            check("an", an, 32'(4'hF & ~(4'h1 << (ND - 1 - d))));
            check("led", LED, 32'(seg_of(int'(msg[(m_fbase + d) % m_len]))));
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic write_char(input int addr, input int code);
        wr_en = 1'b1; wr_addr = 3'(addr); wr_data = 6'(code);
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic do_start(input int len);
        msg_len = 4'(len); start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        cycle();
        pause = 1'b0;
    endtask

    initial begin
        int r;
        reset = 1'b1;
        run(2);
        reset = 1'b0;

        // "HELLO": H E L L O plus filler
        write_char(0, 17); write_char(1, 14); write_char(2, 21);
        write_char(3, 21); write_char(4, 24); write_char(5, 36);
        write_char(6, 36); write_char(7, 36);
        do_start(5);
        run(1);
        check("hello_d0_H", LED, 32'(7'b1001000));
        check("hello_d0_an", an, 32'h7);
        run(64);
        check("hello_step1_E", LED, 32'(7'b0110000));
        run(5 * 64 - 65 + 20);

        // Reset mid-RUN: display off next edge, buffer retained
        run(13);
        reset = 1'b1;
        cycle();
        check("rst_an", an, 32'hF);
        check("rst_led", LED, 32'h7F);
        check("rst_busy", busy, 32'h0);
        reset = 1'b0;
        do_start(5);
        run(1);
        check("rst_keep_H", LED, 32'(7'b1001000));
        run(40);

        // "Hi" repeated over four digits
        do_start(0);
        stop = 1'b1; cycle(); stop = 1'b0;
        write_char(0, 17); write_char(1, 18);
        do_start(2);
        run(5);
        check("hi_d1_I", LED, 32'(7'b1001111));
        run(160);

        // Pause freezes the scroll, second pause resumes
        do_pause();
        run(250);
        do_pause();
        run(150);

        // stop and start together -> IDLE; start with zero length ignored
        msg_len = 4'd5; stop = 1'b1; start = 1'b1;
        cycle();
        stop = 1'b0; start = 1'b0;
        check("stop_start_busy", busy, 32'h0);
        do_start(0);
        run(5);
        check("zero_len_busy", busy, 32'h0);

        // Invalid code shows a dash
        write_char(0, 50);
        do_start(1);
        run(1);
        check("dash_led", LED, 32'(7'b1111110));
        run(40);

        // Randomized traffic
        for (int it = 0; it < 16; it++) begin
            stop = 1'b1; cycle(); stop = 1'b0;
            for (int a = 0; a < DEPTH; a++) write_char(a, int'($urandom_range(0, 63)));
            do_start(int'($urandom_range(1, 15)));
            for (int c = 0; c < 300; c++) begin
                r = int'($urandom_range(0, 199));
                msg_len = 4'($urandom_range(0, 15));
                pause = (r < 4);
                stop  = (r == 4);
                start = (r == 5 || r == 6);
                cycle();
            end
            pause = 1'b0; stop = 1'b0; start = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
